shift_add_mult_seq: RTL and testbench



---
 rtl/shift_add_mult_seq.sv | 104 ++++++++++
 tb/tb_shift_add_mult_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add unsigned multiplier with a start/busy/done handshake.
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module shift_add_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [2*WIDTH-1:0]   addend;
    logic [WIDTH-1:0]     mplierShifted;
    logic                 lastIter;

    assign addend        = mplier_q[0] ? mcand_q : '0;
    assign mplierShifted = mplier_q >> 1;

    // The sum includes this iteration's add, so the final edge must load it into product.
`ifdef MULT_EARLY_EXIT_EN
    assign lastIter = (cnt_q == LAST_CNT) || (mplierShifted == '0);
`else
    assign lastIter = (cnt_q == LAST_CNT);
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_q + addend;
                mcand_d  = mcand_q << 1;
                mplier_d = mplierShifted;
                cnt_d    = cnt_q + 1'b1;
                if (lastIter) begin
                    product_d = acc_q + addend;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed bench for shift_add_mult_seq: vector table plus hand-written handshake corner cases.
// Latency expectations follow MULT_EARLY_EXIT_EN when it is defined for the build.
module tb_shift_add_mult_seq;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int applied;
    int miscompares;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] prod;
    } vec_t;

    vec_t vecs[10];

    shift_add_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
        applied++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Iterations the core spends in CALC for a given multiplier.
    function automatic int expIters(input logic [WIDTH-1:0] bv);
        int n;
`ifdef MULT_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < WIDTH; i++) if (bv[i]) n = i + 1;
`else
        n = WIDTH;
`endif
        return n;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic [2*WIDTH-1:0] expProd, input string name);
        int n;
        bit seen;
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput({name, " busy after accept"}, 16'(busy), 16'd1);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            n++;
            if (done) seen = 1;
        end
        checkOutput({name, " latency"}, seen ? 16'(n) : 16'hFFFF, 16'(expIters(bv)));
        checkOutput({name, " product"}, 16'(product), 16'(expProd));
        checkOutput({name, " busy in done"}, 16'(busy), 16'd0);
        step();
        checkOutput({name, " done one cycle"}, 16'(done), 16'd0);
    endtask

    initial begin
        int pulses;
        int gap;
        int t1;
        logic [2*WIDTH-1:0] lastProd;

        applied = 0;
        miscompares = 0;
        vecs[0] = '{4'hF, 4'hF, 8'hE1};
        vecs[1] = '{4'h3, 4'h5, 8'h0F};
        vecs[2] = '{4'hA, 4'h0, 8'h00};
        vecs[3] = '{4'hA, 4'h2, 8'h14};
        vecs[4] = '{4'h1, 4'h1, 8'h01};
        vecs[5] = '{4'h0, 4'hF, 8'h00};
        vecs[6] = '{4'h8, 4'h8, 8'h40};
        vecs[7] = '{4'hC, 4'h5, 8'h3C};
        vecs[8] = '{4'h9, 4'h9, 8'h51};
        vecs[9] = '{4'h7, 4'h6, 8'h2A};

        rst = 1'b0;
        start = 1'b0;
        a = 4'h0;
        b = 4'h0;
        step();
        step();
        checkOutput("reset busy", 16'(busy), 16'd0);
        checkOutput("reset done", 16'(done), 16'd0);
        checkOutput("reset product", 16'(product), 16'd0);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            a = 4'(i + 3);
            b = 4'(i + 5);
            step();
            if (busy || done) pulses++;
        end
        checkOutput("idle no activity", 16'(pulses), 16'd0);
        checkOutput("idle product held", 16'(product), 16'd0);

        for (int i = 0; i < 10; i++)
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));

        // Start pulsed mid-CALC with new operands must be ignored.
        a = 4'h3;
        b = 4'h5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 4'h9;
        b = 4'h9;
        start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        lastProd = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) begin
                pulses++;
                lastProd = product;
            end
        end
        checkOutput("ignored start pulses", 16'(pulses), 16'd1);
        checkOutput("ignored start product", 16'(lastProd), 16'h0F);

        // Asynchronous reset while calculating drops the operation.
        a = 4'h7;
        b = 4'h6;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("midreset busy", 16'(busy), 16'd0);
        checkOutput("midreset done", 16'(done), 16'd0);
        checkOutput("midreset product", 16'(product), 16'd0);
        step();
        step();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) pulses++;
        end
        checkOutput("midreset no done", 16'(pulses), 16'd0);
        applyStimulus(4'h2, 4'h8, 8'h10, "after reset");

        // Start held high: back-to-back operations, product held between completions.
        a = 4'h5;
        b = 4'hB;
        start = 1'b1;
        t1 = -1;
        gap = -1;
        pulses = 0;
        for (int i = 0; i < 30 && gap < 0; i++) begin
            step();
            if (done) begin
                if (t1 < 0) begin
                    t1 = i;
                    checkOutput("b2b first product", 16'(product), 16'h37);
                    a = 4'h6;
                    b = 4'h9;
                end else begin
                    gap = i - t1;
                    checkOutput("b2b second product", 16'(product), 16'h36);
                end
            end else if (t1 >= 0 && product !== 8'h37) begin
                pulses++;
            end
        end
        start = 1'b0;
        checkOutput("b2b period", 16'(gap), 16'(expIters(4'h9) + 2));
        checkOutput("b2b product held", 16'(pulses), 16'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
